// File: rtl/render_arbiter.sv
// Round-robin arbiter granting one render requester at a time the VGA write port.
// Optional grant watchdog enabled by defining RENDER_ARB_TIMEOUT_EN.
module render_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SCREEN_X = 640,
    parameter int SCREEN_Y = 480,
    parameter int TIMEOUT  = 4096,
    localparam int XW = $clog2(SCREEN_X) + 1,
    localparam int YW = $clog2(SCREEN_Y) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    done,
    input  logic [NUM_REQ-1:0]    in_valid,
    input  logic [NUM_REQ*XW-1:0] in_x,
    input  logic [NUM_REQ*YW-1:0] in_y,
    input  logic [NUM_REQ*3-1:0]  in_col,
    output logic [NUM_REQ-1:0]    grant,
    output logic [XW-1:0]         vga_x,
    output logic [YW-1:0]         vga_y,
    output logic [2:0]            vga_col,
    output logic                  vga_plot,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam logic [IW-1:0]      LAST_INIT = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t               state_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic [IW-1:0]        last_r;
    logic [IW-1:0]        gidx_r;
    logic [XW-1:0]        vga_x_r;
    logic [YW-1:0]        vga_y_r;
    logic [2:0]           vga_col_r;
    logic                 vga_plot_r;
    logic                 busy_r;

    logic [IW-1:0]        win_idx_s;
    logic                 win_found_s;
    logic                 pix_hit_s;
    logic [XW-1:0]        sel_x_s;
    logic [YW-1:0]        sel_y_s;
    logic [2:0]           sel_col_s;

`ifdef RENDER_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0]        tmo_cnt_r;
    logic                 timeout_err_r;
`endif

    // Round-robin search beginning just after the last winner.
    always_comb begin
        win_idx_s   = last_r;
        win_found_s = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int cand;
            cand = (int'(last_r) + k) % NUM_REQ;
            if (!win_found_s && req[cand]) begin
                win_found_s = 1'b1;
                win_idx_s   = IW'(cand);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Pixel bus slice of the current owner; grant_r is zero outside ACTIVE.
    always_comb begin
        sel_x_s   = '0;
        sel_y_s   = '0;
        sel_col_s = 3'd0;
        pix_hit_s = |(grant_r & in_valid);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx_r == IW'(i)) begin
                sel_x_s   = in_x[i*XW +: XW];
                sel_y_s   = in_y[i*YW +: YW];
                sel_col_s = in_col[i*3 +: 3];
            end else begin
                sel_x_s   = sel_x_s;
            end
        end
    end

    // Arbitration FSM, pixel register and optional watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            grant_r    <= '0;
            last_r     <= LAST_INIT;
            gidx_r     <= '0;
            vga_x_r    <= '0;
            vga_y_r    <= '0;
            vga_col_r  <= 3'd0;
            vga_plot_r <= 1'b0;
            busy_r     <= 1'b0;
`ifdef RENDER_ARB_TIMEOUT_EN
            tmo_cnt_r     <= '0;
            timeout_err_r <= 1'b0;
`endif
        end else begin
            if (pix_hit_s) begin
                vga_plot_r <= 1'b1;
                vga_x_r    <= sel_x_s;
                vga_y_r    <= sel_y_s;
                vga_col_r  <= sel_col_s;
            end else begin
                vga_plot_r <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        state_r <= ACTIVE;
                        grant_r <= ONE_HOT0 << win_idx_s;
                        last_r  <= win_idx_s;
                        gidx_r  <= win_idx_s;
                        busy_r  <= 1'b1;
`ifdef RENDER_ARB_TIMEOUT_EN
                        tmo_cnt_r <= '0;
`endif
                    end else begin
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    // Only the owner's done releases; a same-cycle timeout loses to done.
                    if (done[gidx_r]) begin
                        state_r <= RELEASE;
                        grant_r <= '0;
                    end
`ifdef RENDER_ARB_TIMEOUT_EN
                    else if (tmo_cnt_r == TW'(TIMEOUT - 1)) begin
                        state_r       <= RELEASE;
                        grant_r       <= '0;
                        timeout_err_r <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
`else
                    else begin
                        grant_r <= grant_r;
                    end
`endif
                end
                RELEASE: begin
                    state_r <= IDLE;
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign grant    = grant_r;
    assign vga_x    = vga_x_r;
    assign vga_y    = vga_y_r;
    assign vga_col  = vga_col_r;
    assign vga_plot = vga_plot_r;
    assign busy     = busy_r;
`ifdef RENDER_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_r;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_render_arbiter.sv
// Scoreboard bench for render_arbiter: expected grants and pixels are queued by the
// stimulus and popped by a negedge monitor whenever the DUT raises grant or vga_plot.
module tb_render_arbiter;

    localparam int NUM_REQ = 4;
    localparam int XW = 11;
    localparam int YW = 10;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [2:0]    col;
    } pix_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req, done, in_valid;
    logic [NUM_REQ*XW-1:0] in_x;
    logic [NUM_REQ*YW-1:0] in_y;
    logic [NUM_REQ*3-1:0]  in_col;
    logic [NUM_REQ-1:0]    grant;
    logic [XW-1:0]         vga_x;
    logic [YW-1:0]         vga_y;
    logic [2:0]            vga_col;
    logic                  vga_plot, busy, timeout_err;

    int checks = 0;
    int errors = 0;
    logic [NUM_REQ-1:0] grant_q[$];
    pix_t               pix_q[$];
    logic [NUM_REQ-1:0] prev_grant = '0;

    render_arbiter #(.NUM_REQ(NUM_REQ), .SCREEN_X(640), .SCREEN_Y(480), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done), .in_valid(in_valid),
        .in_x(in_x), .in_y(in_y), .in_col(in_col), .grant(grant),
        .vga_x(vga_x), .vga_y(vga_y), .vga_col(vga_col), .vga_plot(vga_plot),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (grant == '0 && n < 8) begin
            tick();
            n++;
        end
        check("grant_within_bound", int'(grant != '0), 1);
    endtask

    task automatic release_req(input int g);
        done = NUM_REQ'(1) << g;
        tick();
        done = '0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Monitor: compare each new grant and each plotted pixel against the queues.
    always @(negedge clk) begin
        if (grant != '0 && prev_grant == '0) begin
            checks++;
            if (grant_q.size() == 0) begin
                errors++;
                $display("FAIL grant_unexpected: got %b expected none", grant);
            end else begin
                logic [NUM_REQ-1:0] eg;
                eg = grant_q.pop_front();
                if (grant != eg) begin
                    errors++;
                    $display("FAIL grant_order: got %b expected %b", grant, eg);
                end
            end
        end
        prev_grant = grant;
        if (vga_plot) begin
            checks++;
            if (pix_q.size() == 0) begin
                errors++;
                $display("FAIL pixel_unexpected: got (%0d,%0d,%0d) expected none", vga_x, vga_y, vga_col);
            end else begin
                pix_t ep;
                ep = pix_q.pop_front();
                if (vga_x != ep.x || vga_y != ep.y || vga_col != ep.col) begin
                    errors++;
                    $display("FAIL pixel_value: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                             vga_x, vga_y, vga_col, ep.x, ep.y, ep.col);
                end
            end
        end
    end

    initial begin
        automatic int order[5] = '{0, 1, 2, 3, 0};
        automatic int held;
        req = '0; done = '0; in_valid = '0; in_x = '0; in_y = '0; in_col = '0;
        do_reset();
        check("rst_grant", int'(grant), 0);
        check("rst_plot", int'(vga_plot), 0);
        check("rst_x", int'(vga_x), 0);
        check("rst_y", int'(vga_y), 0);
        check("rst_col", int'(vga_col), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tmo", int'(timeout_err), 0);

        // Basic grant, release and 2-cycle turnaround.
        req = 4'b0110;
        grant_q.push_back(4'b0010);
        grant_q.push_back(4'b0100);
        tick();
        check("first_grant", int'(grant), 2);
        check("busy_active", int'(busy), 1);
        done = 4'b0010;
        tick();
        done = '0;
        check("turn_gap1", int'(grant), 0);
        check("busy_release", int'(busy), 1);
        tick();
        check("turn_gap2", int'(grant), 0);
        check("busy_idle", int'(busy), 0);
        tick();
        check("second_grant", int'(grant), 4);
        req = '0;
        release_req(2);

        // Fairness with all requesters active.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            grant_q.push_back(NUM_REQ'(1) << order[i]);
            wait_grant();
            release_req(order[i]);
        end
        req = '0;

        // Owner pixel passes, other requester's strobe is dropped.
        req = 4'b0100;
        grant_q.push_back(4'b0100);
        wait_grant();
        in_x[2*XW +: XW] = 11'd320; in_y[2*YW +: YW] = 10'd240; in_col[2*3 +: 3] = 3'b111;
        in_x[0 +: XW] = 11'd5; in_y[0 +: YW] = 10'd6; in_col[0 +: 3] = 3'b001;
        in_valid = 4'b0101;
        pix_q.push_back('{x: 11'd320, y: 10'd240, col: 3'd7});
        tick();
        in_valid = '0;
        tick();
        check("plot_low_after", int'(vga_plot), 0);
        check("x_hold", int'(vga_x), 320);
        check("y_hold", int'(vga_y), 240);
        // Pixel alongside done is emitted, later strobes are not.
        in_x[2*XW +: XW] = 11'd639; in_y[2*YW +: YW] = 10'd479; in_col[2*3 +: 3] = 3'b010;
        in_valid = 4'b0100;
        done = 4'b0100;
        req = '0;
        pix_q.push_back('{x: 11'd639, y: 10'd479, col: 3'd2});
        tick();
        done = '0;
        in_x[2*XW +: XW] = 11'd1;
        tick();
        tick();
        in_valid = '0;
        tick();
        check("x_last_pixel", int'(vga_x), 639);
        check("col_last_pixel", int'(vga_col), 2);

        // Owner dropping req and a foreign done do not release.
        do_reset();
        req = 4'b0001;
        grant_q.push_back(4'b0001);
        wait_grant();
        req = '0;
        done = 4'b1000;
        tick();
        done = '0;
        check("hold_foreign_done", int'(grant), 1);
        tick();
        tick();
        check("hold_req_drop", int'(grant), 1);
        release_req(0);
        check("released_own_done", int'(grant), 0);

        // Reset mid-grant with pixel pending.
        req = 4'b0010;
        grant_q.push_back(4'b0010);
        wait_grant();
        in_x[1*XW +: XW] = 11'd100;
        in_valid = 4'b0010;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = '0;
        req = '0;
        check("rst_mid_grant", int'(grant), 0);
        check("rst_mid_plot", int'(vga_plot), 0);
        tick();
        check("rst_no_late_plot", int'(vga_plot), 0);
        req = 4'b1111;
        grant_q.push_back(4'b0001);
        wait_grant();
        req = '0;
        release_req(0);

        // Watchdog behaviour.
        req = 4'b0100;
        grant_q.push_back(4'b0100);
        wait_grant();
`ifdef RENDER_ARB_TIMEOUT_EN
        held = 1;
        for (int i = 0; i < 40 && grant != '0; i++) begin
            tick();
            if (grant != '0) held++;
        end
        req = '0;
        check("tmo_active_cycles", held, 16);
        check("tmo_flag", int'(timeout_err), 1);
        repeat (4) tick();
        check("tmo_flag_sticky", int'(timeout_err), 1);
`else
        held = 0;
        repeat (10000) tick();
        check("no_tmo_grant_held", int'(grant), 4);
        check("no_tmo_flag", int'(timeout_err), 0);
        req = '0;
        release_req(2);
`endif

        tick();
        check("grant_queue_drained", grant_q.size(), 0);
        check("pixel_queue_drained", pix_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/render_arbiter.md
RENDER_ARBITER -- requirements
Module: render_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of render requesters (ball, left paddle, right paddle, score).
REQ-002 Parameter SCREEN_X, default 640: screen width; XW = $clog2(SCREEN_X)+1 (11 bits).
REQ-003 Parameter SCREEN_Y, default 480: screen height; YW = $clog2(SCREEN_Y)+1 (10 bits).
REQ-004 Parameter TIMEOUT, default 4096: maximum grant duration in cycles; used only with RENDER_ARB_TIMEOUT_EN.
REQ-005 clk  input  1  single system clock; all logic is clocked on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req  input  NUM_REQ  per-requester level request for the VGA write port.
REQ-008 done  input  NUM_REQ  per-requester one-cycle pulse signalling that its render sequence is complete.
REQ-009 in_valid  input  NUM_REQ  per-requester pixel strobe.
REQ-010 in_x / in_y / in_col  input  NUM_REQ*XW / NUM_REQ*YW / NUM_REQ*3  flattened pixel buses; requester i occupies slice i.
REQ-011 grant  output  NUM_REQ  one-hot grant; all zero when no requester owns the port.
REQ-012 vga_x / vga_y / vga_col / vga_plot  output  XW / YW / 3 / 1  registered VGA write port.
REQ-013 busy  output  1  high while the FSM is in ACTIVE or RELEASE.
REQ-014 timeout_err  output  1  sticky flag set when a grant is revoked by the watchdog.

Function
REQ-015 FSM states: IDLE, ACTIVE and RELEASE; all transitions occur on clk edges.
REQ-016 IDLE with req != 0: select the winner by round-robin starting at (last+1) mod NUM_REQ, go to ACTIVE, assert grant[winner] and set last = winner.
REQ-017 IDLE with req == 0: remain in IDLE with grant = 0.
REQ-018 Grant latency: req sampled at edge n gives grant high after edge n, i.e. visible 1 cycle later.
REQ-019 ACTIVE: grant is held constant; deasserting req[g] has no effect; only done[g] releases the port.
REQ-020 ACTIVE and done[g] sampled high: clear grant and go to RELEASE; RELEASE goes to IDLE unconditionally after one cycle.
REQ-021 Minimum turnaround between consecutive grants is therefore 2 cycles with grant = 0.
REQ-022 Non-granted requesters: done and in_valid are ignored entirely.
REQ-023 Pixel path, 1-cycle latency: when grant[g] & in_valid[g] is sampled, the next cycle presents vga_x/y/col = slice g and vga_plot = 1.
REQ-024 Otherwise vga_plot = 0 and vga_x, vga_y and vga_col hold their previous values.
REQ-025 A pixel strobed in the same cycle as done[g] is still emitted; in_valid in RELEASE or IDLE is never emitted.
REQ-026 Multiple done bits high at once: only done[g] is honoured.
REQ-027 The round-robin pointer wraps from NUM_REQ-1 to 0.

Reset
REQ-028 While reset is sampled high: state = IDLE, grant = 0, vga_plot = 0, vga_x = vga_y = 0, vga_col = 0, busy = 0, timeout_err = 0, last = NUM_REQ-1 (so requester 0 has first priority).
REQ-029 Reset mid-grant drops grant and vga_plot on the same edge; no pixel pending at reset is emitted afterwards.

Configuration
REQ-030 Macro RENDER_ARB_TIMEOUT_EN defined: a counter clears on entry to ACTIVE and increments each ACTIVE cycle.
REQ-031 With the macro, reaching TIMEOUT-1 without done forces the RELEASE transition and sets timeout_err, which holds until reset.
REQ-032 Macro not defined: no counter is instantiated, timeout_err is tied to 0 and ACTIVE waits indefinitely for done.

Verification
REQ-033 Reset, then req = 4'b0110 -> grant = 4'b0010 after 1 cycle; done[1] pulse -> grant = 0 for 2 cycles, then grant = 4'b0100.
REQ-034 All four req held high, each grant answered by a done pulse -> grant order 0,1,2,3,0 with no starvation.
REQ-035 Granted to requester 2, in_valid[2] = 1 with x = 320, y = 240, col = 3'b111; in_valid[0] = 1 simultaneously -> next cycle vga_plot = 1, vga = (320, 240, 7); requester 0 pixel never appears.
REQ-036 Granted to requester 0, req[0] drops while done[3] pulses -> grant stays 4'b0001 until done[0].
REQ-037 Reset asserted during ACTIVE with in_valid high -> next cycle grant = 0, vga_plot = 0, and requester 0 is granted first on the next request.
REQ-038 RENDER_ARB_TIMEOUT_EN defined, TIMEOUT = 16, no done -> grant drops after 16 ACTIVE cycles, timeout_err = 1 and stays 1; macro undefined -> grant still held after 10000 cycles.
